// File: rtl/vit_pkt_sequencer.sv
// vit_pkt_sequencer: streams 16-bit FIFO packets to a Viterbi core as 2-bit symbol pairs
// Ports:
//   clk, rst_n              rising-edge clock, synchronous active-low reset
//   fifo_empty_i            packet FIFO empty flag
//   fifo_rdata_i            FIFO read data, valid the cycle after fifo_rd_o
//   fifo_rd_o               one-cycle FIFO pop strobe (combinational)
//   core_stall_i            core cannot accept a symbol this cycle
//   sym_o, sym_valid_o      symbol pair {g1,g2} and its accept strobe, MSB pair first
//   sym_flush_o             current symbol is traceback flush padding
//   flush_done_o            pulse alongside the last flush symbol
//   busy_o                  state is not IDLE
//   pkt_cnt_o               wrapping count of fully streamed packets
// Build option: define VIT_SEQ_AUTOFLUSH_EN to add the idle-timeout flush of TBL+1 zero symbols.
module vit_pkt_sequencer #(
    parameter int TBL        = 15,
    parameter int FLUSH_IDLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_empty_i,
    input  logic [15:0] fifo_rdata_i,
    output logic        fifo_rd_o,
    input  logic        core_stall_i,
    output logic [1:0]  sym_o,
    output logic        sym_valid_o,
    output logic        sym_flush_o,
    output logic        flush_done_o,
    output logic        busy_o,
    output logic [15:0] pkt_cnt_o
);
    // one index serves both the 8 data symbols and the TBL+1 flush symbols
    localparam int IW = ($clog2(TBL + 1) > 3) ? $clog2(TBL + 1) : 3;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
`ifdef VIT_SEQ_AUTOFLUSH_EN
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;
`endif
    if (FLUSH_IDLE < 1 || FLUSH_IDLE > 255) begin : g_bad_flush_idle
        $error("FLUSH_IDLE must lie in 1..255");
    end
    logic [2:0]    state_q, state_d;
    logic [15:0]   shift_q, shift_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   pkt_q, pkt_d;
    logic [1:0]    sym_q, sym_d;
    logic          valid_q, valid_d;
    logic          busy_q;
    logic          pop;
`ifdef VIT_SEQ_AUTOFLUSH_EN
    logic [7:0]    idle_q, idle_d;
    logic          flush_q, flush_d;
    logic          done_q, done_d;
`endif
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        pkt_d   = pkt_q;
        sym_d   = 2'b00;
        valid_d = 1'b0;
        pop     = 1'b0;
`ifdef VIT_SEQ_AUTOFLUSH_EN
        idle_d  = idle_q;
        flush_d = 1'b0;
        done_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                pop     = !fifo_empty_i && !core_stall_i;
                state_d = pop ? LOAD : IDLE;
            end
            LOAD: begin
                shift_d = fifo_rdata_i;
                idx_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: if (!core_stall_i) begin
                sym_d   = shift_q[15:14];
                valid_d = 1'b1;
                shift_d = {shift_q[13:0], 2'b00};
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(7)) begin
                    pkt_d = pkt_q + 16'd1;
                    // popping on the last symbol leaves a single LOAD bubble between packets
                    pop   = !fifo_empty_i;
`ifdef VIT_SEQ_AUTOFLUSH_EN
                    idle_d  = '0;
                    state_d = pop ? LOAD : WAIT;
`else
                    state_d = pop ? LOAD : IDLE;
`endif
                end
            end
`ifdef VIT_SEQ_AUTOFLUSH_EN
            WAIT: begin
                pop = !fifo_empty_i && !core_stall_i;
                if (pop) begin
                    state_d = LOAD;
                    idle_d  = '0;
                end else if (fifo_empty_i && idle_q == 8'(FLUSH_IDLE - 1)) begin
                    state_d = FLUSH;
                    idx_d   = '0;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
            FLUSH: if (!core_stall_i) begin
                valid_d = 1'b1;
                flush_d = 1'b1;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(TBL)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            pkt_q   <= '0;
            sym_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef VIT_SEQ_AUTOFLUSH_EN
            idle_q  <= '0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            pkt_q   <= pkt_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
            busy_q  <= state_d != IDLE;
`ifdef VIT_SEQ_AUTOFLUSH_EN
            idle_q  <= idle_d;
            flush_q <= flush_d;
            done_q  <= done_d;
`endif
        end
    end
    // gated by reset so a held reset never pops (and loses) a packet
    assign fifo_rd_o   = pop && rst_n;
    assign sym_o       = sym_q;
    assign sym_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign pkt_cnt_o   = pkt_q;
`ifdef VIT_SEQ_AUTOFLUSH_EN
    assign sym_flush_o  = flush_q;
    assign flush_done_o = done_q;
`else
    assign sym_flush_o  = 1'b0;
    assign flush_done_o = 1'b0;
`endif
endmodule

// File: tb/tb_vit_pkt_sequencer.sv
// tb_vit_pkt_sequencer: directed self-checking bench for vit_pkt_sequencer
module tb_vit_pkt_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_stall_i = 1'b0;
    logic [15:0] rdata = '0;
    logic        empty;
    logic        fifo_rd_o, sym_valid_o, sym_flush_o, flush_done_o, busy_o;
    logic [1:0]  sym_o;
    logic [15:0] pkt_cnt_o;
    logic [15:0] mem [0:15];
    int wr_ptr = 0, rd_ptr = 0;
    logic rd_seen = 1'b0;
    int cyc = 0, n = 0, done_cnt = 0, done_cyc = 0, bad_rd = 0, bad_sym = 0;
    logic [1:0] sym_log [0:255];
    logic       flg_log [0:255];
    int         cyc_log [0:255];
    int n_chk = 0, n_fail = 0, base = 0, done_base = 0, pc = 0, cnt = 0;
    logic [1:0] exp_e217 [8] = '{2'd3, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3};
    logic [1:0] exp_0f00 [8] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [1:0] exp_a5a5 [8] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
    assign empty = (wr_ptr == rd_ptr);
    vit_pkt_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty_i(empty), .fifo_rdata_i(rdata), .fifo_rd_o(fifo_rd_o),
        .core_stall_i(core_stall_i),
        .sym_o(sym_o), .sym_valid_o(sym_valid_o), .sym_flush_o(sym_flush_o),
        .flush_done_o(flush_done_o), .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o)
    );
    initial forever #5 clk = ~clk;
    // FIFO model: a pop seen at the edge presents its data the following cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_seen) begin
            rdata  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end
    always @(negedge clk) begin
        rd_seen = fifo_rd_o;
        if (fifo_rd_o && core_stall_i) bad_rd++;
        if (!sym_valid_o && sym_o != 2'b00) bad_sym++;
        if (sym_valid_o) begin
            sym_log[n] = sym_o;
            flg_log[n] = sym_flush_o;
            cyc_log[n] = cyc;
            n++;
        end
        if (flush_done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end
    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic [15:0] d);
        mem[wr_ptr] = d;
        wr_ptr++;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        base      = n;
        done_base = done_cnt;
    endtask
    task automatic wait_n(input int target, input int budget);
        int b = budget;
        while (n < target && b > 0) begin
            step(1);
            b--;
        end
        check("wait_timeout", 32'(n >= target), 32'd1);
    endtask
    task automatic check_quiet(input string tag);
        check({tag, "_sym"},   32'(sym_o),        32'd0);
        check({tag, "_valid"}, 32'(sym_valid_o),  32'd0);
        check({tag, "_flush"}, 32'(sym_flush_o),  32'd0);
        check({tag, "_done"},  32'(flush_done_o), 32'd0);
        check({tag, "_busy"},  32'(busy_o),       32'd0);
        check({tag, "_pkt"},   32'(pkt_cnt_o),    32'd0);
        check({tag, "_rd"},    32'(fifo_rd_o),    32'd0);
    endtask
    initial begin
        // reset state
        step(2);
        check_quiet("reset");
        rst_n = 1'b1;
        step(1);
        base = n;
        // single packet E217
        pc = cyc;
        push(16'hE217);
        #1;
        check("e217_rd", 32'(fifo_rd_o), 32'd1);
        wait_n(base + 8, 40);
        for (int i = 0; i < 8; i++) check($sformatf("e217_sym%0d", i), 32'(sym_log[base + i]), 32'(exp_e217[i]));
        check("e217_latency", 32'(cyc_log[base] - pc), 32'd3);
        check("e217_consecutive", 32'(cyc_log[base + 7] - cyc_log[base]), 32'd7);
        check("e217_pkt", 32'(pkt_cnt_o), 32'd1);
`ifdef VIT_SEQ_AUTOFLUSH_EN
        wait_n(base + 24, 80);
        cnt = 0;
        for (int i = 8; i < 24; i++) if (sym_log[base + i] != 2'b00 || !flg_log[base + i]) cnt++;
        check("flush_syms", 32'(cnt), 32'd0);
        check("flush_idle_gap", 32'(cyc_log[base + 8] - cyc_log[base + 7]), 32'd5);
        check("flush_consecutive", 32'(cyc_log[base + 23] - cyc_log[base + 8]), 32'd15);
        check("flush_done_cnt", 32'(done_cnt - done_base), 32'd1);
        check("flush_done_cyc", 32'(done_cyc), 32'(cyc_log[base + 23]));
        check("flush_busy", 32'(busy_o), 32'd0);
`else
        step(100);
        check("noflush_count", 32'(n - base), 32'd8);
        check("noflush_done", 32'(done_cnt - done_base), 32'd0);
        check("noflush_busy", 32'(busy_o), 32'd0);
`endif
        // back-to-back E217, 0F00
        do_reset();
        push(16'hE217);
        push(16'h0F00);
        wait_n(base + 16, 60);
        for (int i = 0; i < 8; i++) check($sformatf("b2b_a%0d", i), 32'(sym_log[base + i]), 32'(exp_e217[i]));
        for (int i = 0; i < 8; i++) check($sformatf("b2b_b%0d", i), 32'(sym_log[base + 8 + i]), 32'(exp_0f00[i]));
        cnt = 0;
        for (int i = 0; i < 16; i++) if (flg_log[base + i]) cnt++;
        check("b2b_noflush", 32'(cnt), 32'd0);
        check("b2b_bubble", 32'(cyc_log[base + 8] - cyc_log[base + 7]), 32'd2);
        check("b2b_pkt", 32'(pkt_cnt_o), 32'd2);
        // stall: first blocks the pop from IDLE, then holds symbol 4 of A5A5 for 3 cycles
        do_reset();
        core_stall_i = 1'b1;
        push(16'hA5A5);
        step(3);
        check("stall_idle_busy", 32'(busy_o), 32'd0);
        check("stall_idle_rd", 32'(fifo_rd_o), 32'd0);
        core_stall_i = 1'b0;
        #1;
        check("stall_release_rd", 32'(fifo_rd_o), 32'd1);
        wait_n(base + 2, 40);
        core_stall_i = 1'b1;
        step(3);
        core_stall_i = 1'b0;
        wait_n(base + 8, 40);
        for (int i = 0; i < 8; i++) check($sformatf("a5a5_sym%0d", i), 32'(sym_log[base + i]), 32'(exp_a5a5[i]));
        check("a5a5_stall_gap", 32'(cyc_log[base + 3] - cyc_log[base + 2]), 32'd4);
        check("a5a5_pkt", 32'(pkt_cnt_o), 32'd1);
`ifdef VIT_SEQ_AUTOFLUSH_EN
        // FIFO fills during flush symbol 5: flush runs to completion, pop follows from IDLE
        do_reset();
        push(16'hE217);
        wait_n(base + 12, 60);
        push(16'h0F00);
        #1;
        check("mid_flush_rd", 32'(fifo_rd_o), 32'd0);
        wait_n(base + 32, 80);
        cnt = 0;
        for (int i = 8; i < 24; i++) if (sym_log[base + i] != 2'b00 || !flg_log[base + i]) cnt++;
        check("mid_flush_syms", 32'(cnt), 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("mid_flush_b%0d", i), 32'(sym_log[base + 24 + i]), 32'(exp_0f00[i]));
        check("mid_flush_done", 32'(done_cnt - done_base), 32'd1);
        check("mid_flush_repop_gap", 32'(cyc_log[base + 24] - cyc_log[base + 23]), 32'd3);
        check("mid_flush_pkt", 32'(pkt_cnt_o), 32'd2);
`endif
        // reset during symbol 3 of E217
        do_reset();
        push(16'hE217);
        wait_n(base + 2, 40);
        rst_n = 1'b0;
        step(1);
        check_quiet("midrst");
        rst_n = 1'b1;
        step(20);
        check("midrst_count", 32'(n - base), 32'd3);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_cnt - done_base), 32'd0);
        check("midrst_pkt", 32'(pkt_cnt_o), 32'd0);
        // whole-run invariants
        check("rd_while_stall", 32'(bad_rd), 32'd0);
        check("sym_nonzero_invalid", 32'(bad_sym), 32'd0);
        check("fifo_drained", 32'(rd_ptr), 32'(wr_ptr));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
